// File: rtl/io_line_xfer_pkg.sv
// Shared types and constants for the io_line_xfer half-duplex serial transfer block.
package io_line_xfer_pkg;

  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_TX   = 3'd1;
  localparam logic [2:0] ENC_TA   = 3'd2;
  localparam logic [2:0] ENC_RX   = 3'd3;
  localparam logic [2:0] ENC_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ENC_IDLE,
    ST_TX   = ENC_TX,
    ST_TA   = ENC_TA,
    ST_RX   = ENC_RX,
    ST_DONE = ENC_DONE
  } state_e;

  localparam int WIDTH_MIN      = 2;
  localparam int WIDTH_MAX      = 32;
  localparam int TURNAROUND_MIN = 1;
  localparam int TURNAROUND_MAX = 15;

  // Even parity over a zero-extended word (caller pads to 33 bits).
  function automatic logic even_parity(input logic [32:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/io_line_shreg.sv
// Parallel-load shift register, MSB out first, serial data shifted in at bit 0.
module io_line_shreg #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           shift,
  input  logic [WIDTH:0] load_val,
  input  logic           ser_in,
  output logic [WIDTH:0] q
);

  logic [WIDTH:0] q_r;

  // Load has priority over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (load) begin
      q_r <= load_val;
    end else if (shift) begin
      q_r <= {q_r[WIDTH-1:0], ser_in};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/io_line_xfer.sv
// Half-duplex line transfer: send a word on IO, release it, receive a word back.
// Optional parity bit enabled by macro IO_LINE_XFER_PARITY_EN.
module io_line_xfer
  import io_line_xfer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_valid,
  output logic             I_ready,
  inout  wire              IO,
  output logic [WIDTH-1:0] O_data,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             busy,
  output logic             parity_err
);

`ifdef IO_LINE_XFER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
  localparam logic [3:0]    LAST_TA  = 4'(TURNAROUND - 1);

  state_e           state_r, state_nx_s;
  logic [CW-1:0]    bit_cnt_r;
  logic [3:0]       ta_cnt_r;
  logic             oe_r, i_ready_r, o_valid_r, busy_r, perr_r;
  logic [WIDTH-1:0] o_data_r;
  logic             accept_s, shift_s, ser_in_s;
  logic [WIDTH:0]   load_val_s, sh_q_s;
  logic [WIDTH-1:0] rx_data_s;
  logic             rx_perr_s;

  assign accept_s = I_valid && i_ready_r;
  assign shift_s  = (state_r == ST_TX) || (state_r == ST_RX);
  assign ser_in_s = (state_r == ST_RX) ? IO : 1'b0;

`ifdef IO_LINE_XFER_PARITY_EN
  assign load_val_s = {I_data, even_parity({{(33-WIDTH){1'b0}}, I_data})};
  // Final bit arrives on the same edge that loads O_data, so take it straight from IO.
  assign rx_data_s  = sh_q_s[WIDTH-1:0];
  assign rx_perr_s  = even_parity({{(33-WIDTH){1'b0}}, rx_data_s}) ^ IO;
`else
  assign load_val_s = {I_data, 1'b0};
  assign rx_data_s  = {sh_q_s[WIDTH-2:0], IO};
  assign rx_perr_s  = 1'b0;
`endif

  io_line_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (CLK),
    .rst_n    (ASYNCRESETN),
    .load     (accept_s),
    .shift    (shift_s),
    .load_val (load_val_s),
    .ser_in   (ser_in_s),
    .q        (sh_q_s)
  );

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_nx_s = ST_TX;   else state_nx_s = ST_IDLE;
      ST_TX:   if (bit_cnt_r == LAST_BIT) state_nx_s = ST_TA; else state_nx_s = ST_TX;
      ST_TA:   if (ta_cnt_r == LAST_TA) state_nx_s = ST_RX;   else state_nx_s = ST_TA;
      ST_RX:   if (bit_cnt_r == LAST_BIT) state_nx_s = ST_DONE; else state_nx_s = ST_RX;
      ST_DONE: if (O_ready) state_nx_s = ST_IDLE;  else state_nx_s = ST_DONE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, counters and registered output decodes.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      ta_cnt_r  <= 4'd0;
      oe_r      <= 1'b0;
      i_ready_r <= 1'b0;
      o_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      perr_r    <= 1'b0;
      o_data_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      // Counters restart on every state entry and stop at the exit count.
      if (state_nx_s != state_r) begin
        bit_cnt_r <= '0;
        ta_cnt_r  <= 4'd0;
      end else begin
        if (shift_s) bit_cnt_r <= bit_cnt_r + CW'(1);
        if (state_r == ST_TA) ta_cnt_r <= ta_cnt_r + 4'd1;
      end
      oe_r      <= (state_nx_s == ST_TX);
      i_ready_r <= (state_nx_s == ST_IDLE);
      busy_r    <= (state_nx_s != ST_IDLE);
      o_valid_r <= (state_nx_s == ST_DONE);
      if ((state_r == ST_RX) && (state_nx_s == ST_DONE)) begin
        o_data_r <= rx_data_s;
        perr_r   <= rx_perr_s;
      end else if (state_nx_s != ST_DONE) begin
        perr_r   <= 1'b0;
      end
    end
  end

  assign IO         = oe_r ? sh_q_s[WIDTH] : 1'bz;
  assign I_ready    = i_ready_r;
  assign O_valid    = o_valid_r;
  assign O_data     = o_data_r;
  assign busy       = busy_r;
  assign parity_err = perr_r;

endmodule
